// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN systolic matrix multiply: loads A then B over a packed bus,
// runs them through a skewed PE grid, then streams C row-major with ready/valid.

module systolic_mm_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a,
  input  logic              a_vld,
  input  logic [DATA_W-1:0] b,
  input  logic              b_vld,
  output logic [ACC_W-1:0]  acc
);
  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    ax, bx, prod;
  logic [ACC_W-1:0] prod_x;

  // Extending both operands to the product width keeps the low PW bits exact in either mode.
  assign ax     = {{DATA_W{sgn & a[DATA_W-1]}}, a};
  assign bx     = {{DATA_W{sgn & b[DATA_W-1]}}, b};
  assign prod   = ax * bx;
  assign prod_x = {{(ACC_W-PW){sgn & prod[PW-1]}}, prod};

  always_ff @(posedge clk)
    if (reset || clr)                acc <= '0;
    else if (en && a_vld && b_vld)   acc <= acc + prod_x;
endmodule

module systolic_mm_engine #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int BUS_W  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             accumulate,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  localparam int EPB = BUS_W / DATA_W;
  localparam int NN  = N * N;
  localparam int NE  = 2 * NN;
  localparam int CMP = 3 * N - 2;
  localparam int MW  = $clog2(NE);
  localparam int EW  = $clog2(NE + EPB);
  localparam int CW  = $clog2(CMP + 1);
  localparam int DW  = $clog2(NN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;
  state_t state, nxt;

  logic              sgn_q;
  logic [EW-1:0]     ecnt;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     drain_idx, drain_nxt;
  logic [DATA_W-1:0] mem [NE];
  logic              start_acc, beat, last_beat, fire, computing, clr;

  logic [N-1:0][DATA_W-1:0]          a_e, b_e;
  logic [N-1:0]                      a_ev, b_ev;
  logic [N-1:0][N-2:0][DATA_W-1:0]   a_q;
  logic [N-1:0][N-2:0]               av_q;
  logic [N-2:0][N-1:0][DATA_W-1:0]   b_q;
  logic [N-2:0][N-1:0]               bv_q;
  logic [NN-1:0][ACC_W-1:0]          acc;

  assign start_acc = (state == S_IDLE) && start;
  assign beat      = (state == S_LOAD) && in_valid;
  assign last_beat = (int'(ecnt) + EPB) >= NE;
  assign fire      = out_valid && out_ready;
  assign computing = (state == S_COMPUTE);
  assign clr       = start_acc && !accumulate;
  assign drain_nxt = drain_idx + DW'(1);

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_LOAD;
      S_LOAD:    if (beat && last_beat) nxt = S_COMPUTE;
      S_COMPUTE: if (cnt == CW'(CMP-1)) nxt = S_DRAIN;
      S_DRAIN:   if (fire && out_last) nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Element stream is A row-major then B row-major; spare lanes of the last beat fall off the end.
  always_ff @(posedge clk)
    if (beat)
      for (int k = 0; k < EPB; k++)
        if (int'(ecnt) + k < NE) mem[MW'(int'(ecnt) + k)] <= in_data[k*DATA_W +: DATA_W];

  // Skewed injection: row i of A and column i of B enter i cycles late.
  always_comb begin
    int k;
    a_e  = '0;
    b_e  = '0;
    a_ev = '0;
    b_ev = '0;
    k    = 0;
    for (int i = 0; i < N; i++) begin
      k       = int'(cnt) - i;
      a_ev[i] = computing && (k >= 0) && (k < N);
      b_ev[i] = a_ev[i];
      if (a_ev[i]) begin
        a_e[i] = mem[MW'(i*N + k)];
        b_e[i] = mem[MW'(NN + k*N + i)];
      end
    end
  end

  always_ff @(posedge clk)
    if (reset) begin
      a_q <= '0; av_q <= '0; b_q <= '0; bv_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        a_q[i][0] <= a_e[i];
        av_q[i][0] <= a_ev[i];
        b_q[0][i] <= b_e[i];
        bv_q[0][i] <= b_ev[i];
        for (int j = 1; j < N-1; j++) begin
          a_q[i][j]  <= a_q[i][j-1];
          av_q[i][j] <= av_q[i][j-1];
          b_q[j][i]  <= b_q[j-1][i];
          bv_q[j][i] <= bv_q[j-1][i];
        end
      end
    end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] pa, pb;
      logic              pav, pbv;
      if (j == 0) begin : g_al
        assign pa = a_e[i];
        assign pav = a_ev[i];
      end else begin : g_ai
        assign pa = a_q[i][j-1];
        assign pav = av_q[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign pb = b_e[j];
        assign pbv = b_ev[j];
      end else begin : g_bi
        assign pb = b_q[i-1][j];
        assign pbv = bv_q[i-1][j];
      end
      systolic_mm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .reset(reset), .clr(clr), .en(computing), .sgn(sgn_q),
        .a(pa), .a_vld(pav), .b(pb), .b_vld(pbv), .acc(acc[i*N + j])
      );
    end
  end

  always_ff @(posedge clk)
    if (reset) begin
      sgn_q     <= 1'b0;
      ecnt      <= '0;
      cnt       <= '0;
      drain_idx <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (start_acc) begin
        sgn_q <= signed_mode;
        ecnt  <= '0;
      end
      if (beat) ecnt <= ecnt + EW'(EPB);
      cnt <= computing ? cnt + CW'(1) : '0;
      // First DRAIN cycle primes the output register, which puts out_valid at 3N-1 after the last beat.
      if (state == S_DRAIN) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= acc[drain_idx];
          out_last  <= (drain_idx == DW'(NN-1));
        end else if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            drain_idx <= '0;
          end else begin
            drain_idx <= drain_nxt;
            out_data  <= acc[drain_nxt];
            out_last  <= (drain_nxt == DW'(NN-1));
          end
        end
      end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Randomized self-checking bench for systolic_mm_engine against a plain matrix-product model.

module tb_systolic_mm_engine;
  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int BW  = 64;
  localparam int EPB = BW / DW;
  localparam int NN  = N * N;
  localparam int NE  = 2 * NN;
  localparam int NB  = (NE + EPB - 1) / EPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, signed_mode = 1'b0, accumulate = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last, busy, done;
  logic [AW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] ea [NN];
  logic [DW-1:0] eb [NN];
  logic [AW-1:0] c_model [NN];

  systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .BUS_W(BW)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .accumulate(accumulate), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // C = A x B (+ previous C), each product taken signed or unsigned, sum wrapped to AW bits.
  task automatic model_job(input bit sgn, input bit acc);
    longint x, y;
    if (!acc) for (int e = 0; e < NN; e++) c_model[e] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++) begin
          x = sgn ? longint'($signed(ea[i*N+k])) : longint'(ea[i*N+k]);
          y = sgn ? longint'($signed(eb[k*N+j])) : longint'(eb[k*N+j]);
          c_model[i*N+j] = c_model[i*N+j] + AW'(x * y);
        end
  endtask

  function automatic logic [BW-1:0] beat_data(input int b);
    logic [BW-1:0] d;
    int e;
    d = '0;
    for (int k = 0; k < EPB; k++) begin
      e = b * EPB + k;
      if (e < NN)      d[k*DW +: DW] = ea[e];
      else if (e < NE) d[k*DW +: DW] = eb[e-NN];
      else             d[k*DW +: DW] = 16'hDEAD;
    end
    return d;
  endfunction

  task automatic set_basic();
    ea = '{16'd1, 16'd2, 16'd3, 16'd4};
    eb = '{16'd5, 16'd6, 16'd7, 16'd8};
  endtask

  task automatic start_job(input bit sgn, input bit acc);
    @(negedge clk);
    start = 1'b1; signed_mode = sgn; accumulate = acc;
    @(negedge clk);
    start = 1'b0; signed_mode = ~sgn; accumulate = ~acc;
    chk("busy_after_start", busy, 1);
    chk("in_ready_load", in_ready, 1);
  endtask

  task automatic load_beats(input bit gap, output int acc_edge);
    int b, guard;
    b = 0; guard = 0; acc_edge = 0;
    while (b < NB && guard < 100) begin
      @(negedge clk);
      guard++;
      in_valid = gap ? (guard % 2 == 1) : 1'b1;
      in_data  = beat_data(b);
      if (in_valid && in_ready) begin
        if (b == NB-1) acc_edge = cyc + 1;
        b++;
      end
    end
    chk("load_beats", b, NB);
  endtask

  task automatic run_job(input bit sgn, input bit acc, input bit gap, input bit stall, input bit noise);
    int acc_edge, idx, guard;
    bit first, prev_stall;
    logic [AW-1:0] prev_data;
    model_job(sgn, acc);
    start_job(sgn, acc);
    load_beats(gap, acc_edge);
    @(negedge clk);
    if (noise) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      @(negedge clk);
      in_data = ~in_data;
    end
    in_valid = 1'b0;
    idx = 0; guard = 0; first = 1'b1; prev_stall = 1'b0; prev_data = '0;
    while (idx < NN && guard < 400) begin
      @(negedge clk);
      guard++;
      out_ready = stall ? (guard % 2 == 1) : 1'b1;
      start = noise && out_valid && (idx == 1);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      prev_stall = 1'b0;
      if (out_valid) begin
        if (first) begin
          chk("latency", cyc - acc_edge, 3*N - 1);
          first = 1'b0;
        end
        if (out_ready) begin
          chk($sformatf("c%0d", idx), out_data, c_model[idx]);
          chk($sformatf("last%0d", idx), out_last, idx == NN-1);
          idx++;
        end else begin
          prev_stall = 1'b1;
          prev_data  = out_data;
        end
      end
    end
    chk("drain_count", idx, NN);
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("out_valid_at_done", out_valid, 0);
    @(negedge clk);
    chk("done_cleared", done, 0);
  endtask

  initial begin
    int acc_edge;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    for (int e = 0; e < NN; e++) c_model[e] = '0;

    set_basic();
    run_job(0, 0, 0, 0, 0);
    ea = '{16'hFFFF, 16'd2, 16'd3, 16'hFFFC};
    eb = '{16'd1, 16'd0, 16'd0, 16'd1};
    run_job(1, 0, 0, 0, 0);
    set_basic();
    run_job(0, 0, 0, 0, 0);
    run_job(0, 1, 0, 0, 0);
    run_job(0, 0, 0, 0, 0);
    run_job(0, 0, 1, 1, 0);
    for (int e = 0; e < NN; e++) begin ea[e] = 16'hFFFF; eb[e] = 16'hFFFF; end
    run_job(0, 0, 0, 0, 1);

    // Abort mid-COMPUTE; accumulators must come back cleared.
    set_basic();
    start_job(0, 0);
    load_beats(0, acc_edge);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    for (int e = 0; e < NN; e++) c_model[e] = '0;
    run_job(0, 1, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int e = 0; e < NN; e++) begin
        ea[e] = DW'($urandom);
        eb[e] = DW'($urandom);
      end
      run_job(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
